// File: rtl/ttl_lab_pkg.sv
// rtl/ttl_lab_pkg.sv - shared FSM states and widths for the TTL clock conditioner
package ttl_lab_pkg;

    localparam int EDGE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PULSE    = 3'd1,
        ST_WAIT_REL = 3'd2,
        ST_RUN_LO   = 3'd3,
        ST_RUN_HI   = 3'd4
    } state_e;

    // States in which the conditioned clock is driven high
    function automatic logic is_high_state(input state_e s);
        return (s == ST_PULSE) || (s == ST_RUN_HI);
    endfunction

endpackage

// File: rtl/ttl_clock_conditioner_if.sv
// rtl/ttl_clock_conditioner_if.sv - button/run inputs and clock/status outputs
interface ttl_clock_conditioner_if;

    logic                            btn_raw;
    logic                            run;
    logic                            step_clk;
    logic                            btn_db;
    logic [ttl_lab_pkg::EDGE_W-1:0]  edge_cnt;
    logic                            busy;

    modport master (
        output btn_raw, run,
        input  step_clk, btn_db, edge_cnt, busy
    );

    modport slave (
        input  btn_raw, run,
        output step_clk, btn_db, edge_cnt, busy
    );

endinterface

// File: rtl/ttl_debounce.sv
// rtl/ttl_debounce.sv - two-flop synchronizer and counting debouncer
module ttl_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic clr_n,
    input  logic in_raw,
    output logic level,
    output logic commit_rise
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          commit;

    // Count consecutive disagreeing cycles; commit the new level on the DB_CYCLES-th one
    always_comb begin
        commit  = 1'b0;
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                commit  = 1'b1;
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer, debounce counter and accepted level
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= in_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level       = level_q;
    assign commit_rise = commit & sync2_q;

endmodule

// File: rtl/ttl_clock_conditioner.sv
// rtl/ttl_clock_conditioner.sv - single-step / free-run clock source for TTL lab boards
module ttl_clock_conditioner
    import ttl_lab_pkg::*;
#(
    parameter int DB_CYCLES    = 16,
    parameter int PULSE_CYCLES = 4,
    parameter int RUN_DIV      = 8
) (
    input logic                    clk,
    input logic                    clr_n,
    ttl_clock_conditioner_if.slave bus
);

    localparam int TMAX = (PULSE_CYCLES > RUN_DIV) ? PULSE_CYCLES : RUN_DIV;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] RUN_LAST   = TW'(RUN_DIV - 1);

    state_e              state_q, state_d;
    logic [TW-1:0]       tmr_q, tmr_d;
    logic                step_clk_q, step_clk_d;
    logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic                btn_db;
    logic                commit_rise;

    ttl_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .clk         (clk),
        .clr_n       (clr_n),
        .in_raw      (bus.btn_raw),
        .level       (btn_db),
        .commit_rise (commit_rise)
    );

    // Next state and phase timer; the timer restarts at zero on every state change
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                tmr_d = '0;
                if (bus.run) begin
                    state_d = ST_RUN_LO;
                end else if (commit_rise) begin
                    state_d = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (tmr_q == PULSE_LAST) begin
                    tmr_d   = '0;
                    state_d = bus.run ? ST_RUN_LO : ST_WAIT_REL;
                end
            end
            ST_WAIT_REL: begin
                tmr_d = '0;
                if (!btn_db) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN_LO: begin
                if (!bus.run) begin
                    tmr_d   = '0;
                    state_d = ST_IDLE;
                end else if (tmr_q == RUN_LAST) begin
                    tmr_d   = '0;
                    state_d = ST_RUN_HI;
                end
            end
            ST_RUN_HI: begin
                // The high phase always runs to completion so no short clock pulse escapes
                if (tmr_q == RUN_LAST) begin
                    tmr_d   = '0;
                    state_d = bus.run ? ST_RUN_LO : ST_IDLE;
                end
            end
            default: begin
                tmr_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Clock output is a registered copy of the state's level; count its rising edges
    always_comb begin
        step_clk_d = is_high_state(state_q);
        edge_cnt_d = edge_cnt_q;
        if (step_clk_d && !step_clk_q) begin
            edge_cnt_d = edge_cnt_q + 1'b1;
        end
    end

    // State, timer, clock and edge counter registers
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            step_clk_q <= 1'b0;
            edge_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            step_clk_q <= step_clk_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

    assign bus.step_clk = step_clk_q;
    assign bus.btn_db   = btn_db;
    assign bus.edge_cnt = edge_cnt_q;
    assign bus.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ttl_clock_conditioner.sv
// tb/tb_ttl_clock_conditioner.sv - self-checking bench for ttl_clock_conditioner
module tb_ttl_clock_conditioner;

    localparam int DB = 4;
    localparam int PC = 3;
    localparam int RD = 2;

    logic clk = 1'b0;
    logic clr_n;

    ttl_clock_conditioner_if bus ();

    ttl_clock_conditioner #(
        .DB_CYCLES    (DB),
        .PULSE_CYCLES (PC),
        .RUN_DIV      (RD)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rises  = 0;
    logic prev_step = 1'b0;

    // Reference model: phase names with a countdown of remaining cycles
    localparam int M_IDLE = 0, M_PULSE = 1, M_WAIT = 2, M_LO = 3, M_HI = 4;
    int         m_phase = M_IDLE;
    int         m_left  = 0;
    int         m_run   = 0;
    int         m_hist[$];
    logic       m_db    = 1'b0;
    logic       m_step  = 1'b0;
    logic       m_busy  = 1'b0;
    logic [7:0] m_cnt   = 8'd0;

    task automatic model_step(input logic c, input logic raw, input logic rn);
        int   bs;
        logic old_db;
        logic old_high;
        logic rise_commit;
        if (!c) begin
            m_phase = M_IDLE; m_left = 0; m_run = 0; m_hist.delete();
            m_db = 1'b0; m_step = 1'b0; m_busy = 1'b0; m_cnt = 8'd0;
            return;
        end
        // btn_raw seen by the debouncer is the sample from two edges ago
        bs          = (m_hist.size() >= 2) ? m_hist[m_hist.size() - 2] : 0;
        old_db      = m_db;
        old_high    = (m_phase == M_PULSE) || (m_phase == M_HI);
        rise_commit = 1'b0;
        if (bs != int'(m_db)) begin
            m_run++;
            if (m_run == DB) begin
                m_db        = logic'(bs);
                m_run       = 0;
                rise_commit = logic'(bs);
            end
        end else begin
            m_run = 0;
        end
        case (m_phase)
            M_IDLE: begin
                if (rn) begin m_phase = M_LO; m_left = RD; end
                else if (rise_commit) begin m_phase = M_PULSE; m_left = PC; end
            end
            M_PULSE: begin
                m_left--;
                if (m_left == 0) begin
                    if (rn) begin m_phase = M_LO; m_left = RD; end
                    else m_phase = M_WAIT;
                end
            end
            M_WAIT: if (!old_db) m_phase = M_IDLE;
            M_LO: begin
                if (!rn) m_phase = M_IDLE;
                else begin
                    m_left--;
                    if (m_left == 0) begin m_phase = M_HI; m_left = RD; end
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) begin
                    if (rn) begin m_phase = M_LO; m_left = RD; end
                    else m_phase = M_IDLE;
                end
            end
        endcase
        if (old_high && !m_step) m_cnt = m_cnt + 8'd1;
        m_step = old_high;
        m_busy = (m_phase != M_IDLE);
        m_hist.push_back(int'(raw));
        if (m_hist.size() > 2) void'(m_hist.pop_front());
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive inputs, advance model, compare all outputs against it
    task automatic cyc(input logic c, input logic raw, input logic rn);
        clr_n       = c;
        bus.btn_raw = raw;
        bus.run     = rn;
        @(posedge clk);
        model_step(c, raw, rn);
        #1;
        checks++;
        if ({bus.step_clk, bus.btn_db, bus.busy, bus.edge_cnt} !== {m_step, m_db, m_busy, m_cnt}) begin
            errors++;
            $display("FAIL model t=%0t: got step=%b db=%b busy=%b cnt=%0d expected step=%b db=%b busy=%b cnt=%0d",
                     $time, bus.step_clk, bus.btn_db, bus.busy, bus.edge_cnt, m_step, m_db, m_busy, m_cnt);
        end
        if (bus.step_clk === 1'b1 && prev_step === 1'b0) rises++;
        prev_step = bus.step_clk;
    endtask

    typedef struct {
        logic       clr_n;
        logic       raw;
        logic       run;
        logic       step;
        logic       db;
        logic       busy;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];

    initial begin
        vec_t v;
        logic r;
        logic rn;
        logic c;

        // Clean press: held 20 cycles then released 8 cycles
        for (int i = 0; i < 28; i++) begin
            v.clr_n = 1'b1; v.raw = (i < 20); v.run = 1'b0;
            if (i < 5)       begin v.step = 0; v.db = 0; v.busy = 0; v.cnt = 0; end
            else if (i == 5) begin v.step = 0; v.db = 1; v.busy = 1; v.cnt = 0; end
            else if (i < 9)  begin v.step = 1; v.db = 1; v.busy = 1; v.cnt = 1; end
            else if (i < 25) begin v.step = 0; v.db = 1; v.busy = 1; v.cnt = 1; end
            else if (i == 25) begin v.step = 0; v.db = 0; v.busy = 1; v.cnt = 1; end
            else             begin v.step = 0; v.db = 0; v.busy = 0; v.cnt = 1; end
            tbl.push_back(v);
        end

        clr_n = 1'b0; bus.btn_raw = 1'b0; bus.run = 1'b0;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("reset_step", int'(bus.step_clk), 0);
        chk("reset_db", int'(bus.btn_db), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_cnt", int'(bus.edge_cnt), 0);

        foreach (tbl[i]) begin
            cyc(tbl[i].clr_n, tbl[i].raw, tbl[i].run);
            chk($sformatf("tbl%0d_step", i), int'(bus.step_clk), int'(tbl[i].step));
            chk($sformatf("tbl%0d_db", i), int'(bus.btn_db), int'(tbl[i].db));
            chk($sformatf("tbl%0d_busy", i), int'(bus.busy), int'(tbl[i].busy));
            chk($sformatf("tbl%0d_cnt", i), int'(bus.edge_cnt), int'(tbl[i].cnt));
        end

        // Free run for 40 cycles: low 2 / high 2, first rise 3 edges in
        cyc(0, 0, 0);
        for (int k = 0; k < 40; k++) begin
            cyc(1, 0, 1);
            chk($sformatf("run_step%0d", k), int'(bus.step_clk),
                (k >= 3 && ((k - 3) % 4) < 2) ? 1 : 0);
        end
        chk("run_cnt40", int'(bus.edge_cnt), 10);
        for (int k = 0; k < 4; k++) cyc(1, 0, 0);
        chk("run_stop_step", int'(bus.step_clk), 0);
        chk("run_stop_busy", int'(bus.busy), 0);

        // run drops on first high-state cycle: high phase completes in full
        cyc(0, 0, 0);
        for (int k = 0; k < 3; k++) cyc(1, 0, 1);
        cyc(1, 0, 0);
        chk("drop_hi1", int'(bus.step_clk), 1);
        cyc(1, 0, 0);
        chk("drop_hi2", int'(bus.step_clk), 1);
        cyc(1, 0, 0);
        chk("drop_end_step", int'(bus.step_clk), 0);
        chk("drop_end_busy", int'(bus.busy), 0);

        // Reset in the middle of a pulse, then re-debounce the held button
        cyc(0, 0, 0);
        for (int k = 0; k < 7; k++) cyc(1, 1, 0);
        chk("midrst_pre_step", int'(bus.step_clk), 1);
        cyc(0, 1, 0);
        chk("midrst_step", int'(bus.step_clk), 0);
        chk("midrst_cnt", int'(bus.edge_cnt), 0);
        for (int k = 0; k < 6; k++) cyc(1, 1, 0);
        chk("midrst_k5_step", int'(bus.step_clk), 0);
        cyc(1, 1, 0);
        chk("midrst_k6_step", int'(bus.step_clk), 1);
        chk("midrst_k6_cnt", int'(bus.edge_cnt), 1);
        for (int k = 0; k < 12; k++) cyc(1, 0, 0);

        // Bouncing press yields exactly one pulse
        cyc(0, 0, 0);
        rises = 0;
        for (int k = 0; k < 12; k++) cyc(1, logic'(((k / 2) % 2) == 0), 0);
        for (int k = 0; k < 20; k++) cyc(1, 1, 0);
        for (int k = 0; k < 12; k++) cyc(1, 0, 0);
        chk("bounce_pulses", rises, 1);
        chk("bounce_cnt", int'(bus.edge_cnt), 1);

        // 256 presses wrap the edge counter
        cyc(0, 0, 0);
        rises = 0;
        for (int p = 0; p < 256; p++) begin
            for (int k = 0; k < 12; k++) cyc(1, 1, 0);
            for (int k = 0; k < 10; k++) cyc(1, 0, 0);
        end
        chk("wrap_pulses", rises, 256);
        chk("wrap_cnt", int'(bus.edge_cnt), 0);

        // Randomized traffic against the reference model
        cyc(0, 0, 0);
        r = 1'b0; rn = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 7) == 0) r = ~r;
            if ($urandom_range(0, 39) == 0) rn = ~rn;
            c = ($urandom_range(0, 199) != 0);
            cyc(c, r, rn);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
